alu_ctrl_issue: RTL and testbench
=================================

// Module: alu_ctrl_issue
// PURPOSE
// - Execute-stage issue block that drives the 3-bit alucontrol/operand interface of the ALU.
// - Decodes RV32I ALU, load, store, branch and LUI instructions into alucontrol, op_a and op_b.
// - Registers the decoded result behind a valid/ready handshake with a 2-entry skid buffer (main + skid).
// - Sits between the decode stage (upstream) and the ALU plus EX pipeline register (downstream).
// PARAMETERS
// - XLEN   32  datapath width; only 32 is supported.
// PORTS
// - clk        in   1     rising-edge clock
// - rst_n      in   1     asynchronous active-low reset
// - flush      in   1     synchronous pipeline flush; kills all held entries
// - in_valid   in   1     upstream instruction valid
// - in_ready   out  1     block can accept an instruction this cycle
// - instr      in   32    RV32I instruction word
// - rs1_val    in   XLEN  register-file read value of rs1
// - rs2_val    in   XLEN  register-file read value of rs2
// - out_valid  out  1     op_a/op_b/alucontrol/illegal are valid
// - out_ready  in   1     downstream consumes the entry this cycle
// - op_a       out  XLEN  ALU operand a
// - op_b       out  XLEN  ALU operand b
// - alucontrol out  3     000 ADD, 001 SUB, 010 SLL, 011 SLT, 100 XOR, 101 SRL, 110 OR, 111 AND
// - illegal    out  1     entry is an instruction the ALU cannot execute
// BEHAVIOUR
// - Reset (rst_n=0, async): both entries invalid; out_valid=0, in_ready=1, op_a=op_b=0, alucontrol=000, illegal=0.
// - Handshakes:
//   - Input transfer: in_valid & in_ready. Output transfer: out_valid & out_ready.
//   - in_ready = !skid_valid, a register output with no combinational path from out_ready.
//   - Latency: an accepted instruction is presented on the outputs the next cycle when main is empty or draining.
//   - Throughput: one per cycle while out_ready=1.
//   - If main is held (out_valid & !out_ready) and an input arrives, the input goes to skid; in_ready drops next cycle.
//   - When main drains, skid moves to main in the same edge. Order is strictly FIFO.
//   - Outputs are stable while out_valid & !out_ready.
// - Decode, indexed by opcode instr[6:0]:
//   - 0110011 R-type: op_a=rs1_val, op_b=rs2_val.
//     - funct3 000: ADD if funct7=0000000, SUB if funct7=0100000.
//     - funct3 001 SLL, 010 SLT, 100 XOR, 101 SRL, 110 OR, 111 AND.
//   - 0010011 I-type: op_a=rs1_val, op_b=sext(instr[31:20]). Same funct3 map; 000 is always ADD.
//     - Shifts (001, 101): op_b={27'b0, instr[24:20]}.
//   - 0000011 load: ADD, op_a=rs1_val, op_b=sext(instr[31:20]).
//   - 0100011 store: ADD, op_a=rs1_val, op_b=sext({instr[31:25],instr[11:7]}).
//   - 1100011 branch: SUB, op_a=rs1_val, op_b=rs2_val.
//   - 0110111 LUI: ADD, op_a=0, op_b={instr[31:12],12'b0}.
// - illegal=1 in each of these cases:
//   - funct3 011 (SLTU/SLTIU).
//   - SRA/SRAI (funct3 101 with funct7 0100000).
//   - R-type funct7 not in {0000000, 0100000}, or funct7 0100000 with funct3 not in {000, 101}.
//   - Any other opcode.
//   - Illegal entries still handshake, with op_a=op_b=0 and alucontrol=000.
// - flush=1:
//   - Both entries are invalidated at the next edge, and an input accepted in the same cycle is dropped.
//   - After the flush edge: out_valid=0, in_ready=1.
//   - flush has priority over every simultaneous transfer.
// - Full buffer (main and skid valid): in_ready=0; in_valid is ignored.
// - Reset mid-operation: held entries are discarded immediately; no partial output.
// STRUCTURE
// - Package riscv_pkg holds:
//   - ALU_ADD..ALU_AND codes, matching the ALU encoding above.
//   - Opcode constants OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_LUI.
//   - funct7 constants F7_BASE and F7_ALT.
// - Sub-module alu_ctrl_decode: purely combinational, instr/rs1/rs2 -> {illegal, alucontrol, op_a, op_b}.
// - Top level holds only the skid buffer, which is 2 x (1 + 3 + 2*XLEN) bits plus valid flags.
// TESTING
// - Reset: after rst_n release, out_valid=0, in_ready=1, alucontrol=000, op_a=op_b=0.
// - Decode, one instruction per cycle, out_ready=1:
//   - sub x3,x1,x2 (0x402081B3), rs1=7, rs2=5 -> alucontrol=001, op_a=7, op_b=5 one cycle later.
//   - addi x1,x0,-1 (0xFFF00093) -> alucontrol=000, op_b=0xFFFFFFFF.
//   - slli x1,x1,3 (0x00309093) -> alucontrol=010, op_b=3.
//   - lui x1,0x12345 (0x123450B7) -> alucontrol=000, op_a=0, op_b=0x12345000.
// - Backpressure:
//   - Stream A,B,C with out_ready=0 from the cycle A appears -> B held in skid, in_ready=0, C not accepted.
//   - out_ready=1 for 3 cycles -> A, B, C delivered in order, with no loss or duplication.
// - Illegal: sltu (0x0020B1B3) and srai (0x4030D093) -> illegal=1, alucontrol=000, op_a=op_b=0, handshake completes.
// - Flush with both entries full plus in_valid=1 -> next cycle out_valid=0, in_ready=1; the dropped input never appears.
// - Async reset asserted mid-stream between clock edges -> out_valid=0 immediately; restart with addi decodes correctly.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I constants and the decoded ALU request bundle
// used by the execute-stage issue logic.
package riscv_pkg;

  localparam int DATA_W = 32;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_SLL = 3'b010;
  localparam logic [2:0] ALU_SLT = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SRL = 3'b101;
  localparam logic [2:0] ALU_OR  = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b111;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    logic              illegal;
    logic [2:0]        alu;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } alu_req_t;

  function automatic logic [2:0] f3_alu(
    input logic [2:0] f3
  );
    logic [2:0] r;
    r = ALU_ADD;
    unique case (f3)
      3'b001:  r = ALU_SLL;
      3'b010:  r = ALU_SLT;
      3'b100:  r = ALU_XOR;
      3'b101:  r = ALU_SRL;
      3'b110:  r = ALU_OR;
      3'b111:  r = ALU_AND;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational RV32I decode into alucontrol and ALU operands.
// Anything the ALU cannot execute comes out as a zeroed illegal request.
module alu_ctrl_decode
  import riscv_pkg::*;
(
  input  logic [31:0]       instr,
  input  logic [DATA_W-1:0] rs1_val,
  input  logic [DATA_W-1:0] rs2_val,
  output alu_req_t          req
);

  logic [6:0]        opcode;
  logic [2:0]        f3;
  logic [6:0]        f7;
  logic [DATA_W-1:0] imm_i;
  logic [DATA_W-1:0] imm_s;
  logic [DATA_W-1:0] shamt;
  logic              legal;
  logic [2:0]        alu;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign shamt  = {27'b0, instr[24:20]};

  always_comb begin
    legal = 1'b0;
    alu   = ALU_ADD;
    a     = '0;
    b     = '0;
    case (opcode)
      OP_R: begin
        legal = (f3 != 3'b011) &&
                ((f7 == F7_BASE) ||
                 ((f7 == F7_ALT) && (f3 == 3'b000)));
        alu   = (f3 == 3'b000) ?
                ((f7 == F7_ALT) ? ALU_SUB : ALU_ADD) :
                f3_alu(f3);
        a     = rs1_val;
        b     = rs2_val;
      end
      OP_I: begin
        legal = (f3 != 3'b011) &&
                !((f3 == 3'b101) && (f7 == F7_ALT));
        alu   = f3_alu(f3);
        a     = rs1_val;
        b     = (f3 == 3'b001 || f3 == 3'b101) ? shamt : imm_i;
      end
      OP_LOAD: begin
        legal = 1'b1;
        a     = rs1_val;
        b     = imm_i;
      end
      OP_STORE: begin
        legal = 1'b1;
        a     = rs1_val;
        b     = imm_s;
      end
      OP_BRANCH: begin
        legal = 1'b1;
        alu   = ALU_SUB;
        a     = rs1_val;
        b     = rs2_val;
      end
      OP_LUI: begin
        legal = 1'b1;
        b     = {instr[31:12], 12'b0};
      end
      default: legal = 1'b0;
    endcase
    req = '0;
    if (legal) req = '{illegal: 1'b0, alu: alu, a: a, b: b};
    else       req.illegal = 1'b1;
  end

endmodule

// File: rtl/alu_ctrl_issue.sv
// Execute-stage issue: decoded ALU request behind a main+skid buffer.
// in_ready depends only on the skid flop, never on out_ready.
module alu_ctrl_issue
  import riscv_pkg::*;
#(
  parameter int XLEN = DATA_W
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] op_a,
  output logic [XLEN-1:0] op_b,
  output logic [2:0]      alucontrol,
  output logic            illegal
);

  alu_req_t dec;
  alu_req_t main_q, main_d;
  alu_req_t skid_q, skid_d;
  logic     main_v_q, main_v_d;
  logic     skid_v_q, skid_v_d;
  logic     acc;
  logic     free;

  alu_ctrl_decode u_dec (
    .instr   (instr),
    .rs1_val (rs1_val),
    .rs2_val (rs2_val),
    .req     (dec)
  );

  assign in_ready = !skid_v_q;
  assign acc      = in_valid && !skid_v_q;
  assign free     = !main_v_q || out_ready;

  always_comb begin
    main_d   = main_q;
    skid_d   = skid_q;
    main_v_d = main_v_q;
    skid_v_d = skid_v_q;
    if (flush) begin
      main_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (free) begin
      // Skid is older than any new input, so it refills main first.
      if (skid_v_q) begin
        main_d   = skid_q;
        main_v_d = 1'b1;
        skid_v_d = 1'b0;
      end else begin
        main_v_d = acc;
        if (acc) main_d = dec;
      end
    end else if (acc) begin
      skid_d   = dec;
      skid_v_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q   <= '0;
      skid_q   <= '0;
      main_v_q <= 1'b0;
      skid_v_q <= 1'b0;
    end else begin
      main_q   <= main_d;
      skid_q   <= skid_d;
      main_v_q <= main_v_d;
      skid_v_q <= skid_v_d;
    end
  end

  assign out_valid  = main_v_q;
  assign op_a       = main_q.a;
  assign op_b       = main_q.b;
  assign alucontrol = main_q.alu;
  assign illegal    = main_q.illegal;

endmodule

// File: tb/tb_alu_ctrl_issue.sv
// Bench for alu_ctrl_issue: directed scenarios plus a random stream
// checked against an ISA-table decoder and a 2-deep FIFO queue model.
module tb_alu_ctrl_issue;

  typedef struct packed {
    logic        ill;
    logic [2:0]  alu;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  logic        clk = 0;
  logic        rst_n = 0;
  logic        flush = 0;
  logic        in_valid = 0;
  logic        in_ready;
  logic [31:0] instr = 0;
  logic [31:0] rs1_val = 0;
  logic [31:0] rs2_val = 0;
  logic        out_valid;
  logic        out_ready = 0;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic [2:0]  alucontrol;
  logic        illegal;

  int   checks = 0;
  int   passes = 0;
  exp_t mq[$];

  alu_ctrl_issue dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .instr      (instr),
    .rs1_val    (rs1_val),
    .rs2_val    (rs2_val),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .op_a       (op_a),
    .op_b       (op_b),
    .alucontrol (alucontrol),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  // Reference decoder written as an ISA encoding table.
  function automatic exp_t ref_decode(
    input logic [31:0] i,
    input logic [31:0] r1,
    input logic [31:0] r2
  );
    logic [31:0] ii, si, sh;
    exp_t e;
    ii = {{20{i[31]}}, i[31:20]};
    si = {{20{i[31]}}, i[31:25], i[11:7]};
    sh = {27'b0, i[24:20]};
    e  = '{ill: 1'b1, alu: 3'd0, a: 32'd0, b: 32'd0};
    casez (i)
      32'b0000000_?????_?????_000_?????_0110011: e = '{1'b0, 3'd0, r1, r2};
      32'b0100000_?????_?????_000_?????_0110011: e = '{1'b0, 3'd1, r1, r2};
      32'b0000000_?????_?????_001_?????_0110011: e = '{1'b0, 3'd2, r1, r2};
      32'b0000000_?????_?????_010_?????_0110011: e = '{1'b0, 3'd3, r1, r2};
      32'b0000000_?????_?????_100_?????_0110011: e = '{1'b0, 3'd4, r1, r2};
      32'b0000000_?????_?????_101_?????_0110011: e = '{1'b0, 3'd5, r1, r2};
      32'b0000000_?????_?????_110_?????_0110011: e = '{1'b0, 3'd6, r1, r2};
      32'b0000000_?????_?????_111_?????_0110011: e = '{1'b0, 3'd7, r1, r2};
      32'b???????_?????_?????_000_?????_0010011: e = '{1'b0, 3'd0, r1, ii};
      32'b???????_?????_?????_001_?????_0010011: e = '{1'b0, 3'd2, r1, sh};
      32'b???????_?????_?????_010_?????_0010011: e = '{1'b0, 3'd3, r1, ii};
      32'b???????_?????_?????_100_?????_0010011: e = '{1'b0, 3'd4, r1, ii};
      32'b0100000_?????_?????_101_?????_0010011: e = e;
      32'b???????_?????_?????_101_?????_0010011: e = '{1'b0, 3'd5, r1, sh};
      32'b???????_?????_?????_110_?????_0010011: e = '{1'b0, 3'd6, r1, ii};
      32'b???????_?????_?????_111_?????_0010011: e = '{1'b0, 3'd7, r1, ii};
      32'b???????_?????_?????_???_?????_0000011: e = '{1'b0, 3'd0, r1, ii};
      32'b???????_?????_?????_???_?????_0100011: e = '{1'b0, 3'd0, r1, si};
      32'b???????_?????_?????_???_?????_1100011: e = '{1'b0, 3'd1, r1, r2};
      32'b???????_?????_?????_???_?????_0110111:
        e = '{1'b0, 3'd0, 32'd0, {i[31:12], 12'b0}};
      default: e = e;
    endcase
    return e;
  endfunction

  // One clock: inputs were set after the previous negedge.
  task automatic tick();
    bit acc, drn;
    acc = in_valid && (mq.size() < 2);
    drn = out_ready && (mq.size() > 0);
    @(posedge clk);
    if (flush) mq.delete();
    else begin
      if (drn) void'(mq.pop_front());
      if (acc) mq.push_back(ref_decode(instr, rs1_val, rs2_val));
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0)
      $display("FAIL reset_out_valid got=%b want=0", out_valid);
    else passes++;
    checks++;
    if (in_ready !== 1'b1)
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    else passes++;
    checks++;
    if ({illegal, alucontrol, op_a, op_b} !== 68'd0)
      $display("FAIL reset_outputs got=%b/%h/%h/%h want=0/0/0/0",
               illegal, alucontrol, op_a, op_b);
    else passes++;
  endtask

  task automatic test_decode();
    logic [31:0] ins [4];
    logic [31:0] r1s [4];
    exp_t        want [4];
    ins  = '{32'h402081B3, 32'hFFF00093, 32'h00309093, 32'h123450B7};
    r1s  = '{32'd7, 32'h10, 32'h11, 32'h55};
    want = '{'{1'b0, 3'b001, 32'd7, 32'd5},
             '{1'b0, 3'b000, 32'h10, 32'hFFFFFFFF},
             '{1'b0, 3'b010, 32'h11, 32'd3},
             '{1'b0, 3'b000, 32'd0, 32'h12345000}};
    out_ready = 1;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1;
      instr    = ins[k];
      rs1_val  = r1s[k];
      rs2_val  = 32'd5;
      tick();
      checks++;
      if (out_valid !== 1'b1 ||
          {illegal, alucontrol, op_a, op_b} !== want[k])
        $display("FAIL decode_%0d got=%b/%b/%h/%h/%h want=%h", k,
                 out_valid, illegal, alucontrol, op_a, op_b, want[k]);
      else passes++;
    end
    in_valid = 0;
    tick();
  endtask

  task automatic test_backpressure();
    // A, B, C are addi x1,x0,1/2/3 so op_b names the entry.
    rs1_val = 0;
    out_ready = 0;
    in_valid = 1;
    instr = 32'h00100093;
    tick();
    instr = 32'h00200093;
    tick();
    checks++;
    if (op_b !== 32'd1 || in_ready !== 1'b0 || out_valid !== 1'b1)
      $display("FAIL bp_hold got=b%h rdy%b v%b want=b1 rdy0 v1",
               op_b, in_ready, out_valid);
    else passes++;
    instr = 32'h00300093;
    tick();
    checks++;
    if (op_b !== 32'd1 || in_ready !== 1'b0)
      $display("FAIL bp_full got=b%h rdy%b want=b1 rdy0", op_b, in_ready);
    else passes++;
    out_ready = 1;
    tick();
    checks++;
    if (op_b !== 32'd2 || out_valid !== 1'b1 || in_ready !== 1'b1)
      $display("FAIL bp_b got=b%h v%b rdy%b want=b2 v1 rdy1",
               op_b, out_valid, in_ready);
    else passes++;
    tick();
    in_valid = 0;
    checks++;
    if (op_b !== 32'd3 || out_valid !== 1'b1)
      $display("FAIL bp_c got=b%h v%b want=b3 v1", op_b, out_valid);
    else passes++;
    tick();
    checks++;
    if (out_valid !== 1'b0)
      $display("FAIL bp_empty got=%b want=0", out_valid);
    else passes++;
  endtask

  task automatic test_illegal();
    logic [31:0] ins [2];
    ins = '{32'h0020B1B3, 32'h4030D093};
    out_ready = 1;
    rs1_val = 32'hDEAD0001;
    rs2_val = 32'hBEEF0002;
    for (int k = 0; k < 2; k++) begin
      in_valid = 1;
      instr = ins[k];
      tick();
      checks++;
      if (out_valid !== 1'b1 ||
          {illegal, alucontrol, op_a, op_b} !== {1'b1, 67'd0})
        $display("FAIL illegal_%0d got=%b/%b/%h/%h/%h want=1/1/0/0/0", k,
                 out_valid, illegal, alucontrol, op_a, op_b);
      else passes++;
    end
    in_valid = 0;
    tick();
    checks++;
    if (out_valid !== 1'b0)
      $display("FAIL illegal_drain got=%b want=0", out_valid);
    else passes++;
  endtask

  task automatic test_flush();
    rs1_val = 0;
    out_ready = 0;
    in_valid = 1;
    instr = 32'h00100093;
    tick();
    instr = 32'h00200093;
    tick();
    instr = 32'h00700093;
    flush = 1;
    out_ready = 1;
    tick();
    flush = 0;
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1)
      $display("FAIL flush got=v%b rdy%b want=v0 rdy1", out_valid, in_ready);
    else passes++;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0)
        $display("FAIL flush_ghost_%0d got=%b want=0", k, out_valid);
      else passes++;
    end
  endtask

  task automatic test_async_reset();
    rs1_val = 0;
    out_ready = 0;
    in_valid = 1;
    instr = 32'h00100093;
    tick();
    tick();
    #2 rst_n = 0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || op_b !== 32'd0)
      $display("FAIL async_rst got=v%b rdy%b b%h want=v0 rdy1 b0",
               out_valid, in_ready, op_b);
    else passes++;
    mq.delete();
    in_valid = 0;
    @(negedge clk);
    rst_n = 1;
    out_ready = 1;
    in_valid = 1;
    instr = 32'hFFF00093;
    tick();
    in_valid = 0;
    checks++;
    if (out_valid !== 1'b1 ||
        {illegal, alucontrol, op_a, op_b} !== {4'b0, 32'd0, 32'hFFFFFFFF})
      $display("FAIL async_restart got=%b/%b/%h/%h/%h want=1/0/0/0/ffffffff",
               out_valid, illegal, alucontrol, op_a, op_b);
    else passes++;
    tick();
  endtask

  task automatic test_random();
    logic [6:0] ops [7];
    logic [6:0] f7s [3];
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
            7'b1100011, 7'b0110111, 7'b1111111};
    f7s = '{7'b0000000, 7'b0100000, 7'b0000001};
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      instr     = $urandom;
      instr[6:0] = ops[$urandom_range(0, 6)];
      if (instr[6:0] == 7'b1111111) instr[6:0] = 7'($urandom);
      if ($urandom_range(0, 3) != 0)
        instr[31:25] = f7s[$urandom_range(0, 2)];
      rs1_val = $urandom;
      rs2_val = $urandom;
      tick();
      checks++;
      if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2))
        $display("FAIL rand_hs_%0d got=v%b rdy%b want=v%b rdy%b", n,
                 out_valid, in_ready, mq.size() > 0, mq.size() < 2);
      else passes++;
      if (mq.size() > 0) begin
        checks++;
        if ({illegal, alucontrol, op_a, op_b} !== mq[0])
          $display("FAIL rand_data_%0d got=%b/%h/%h/%h want=%h", n,
                   illegal, alucontrol, op_a, op_b, mq[0]);
        else passes++;
      end
    end
    flush = 0;
    in_valid = 0;
  endtask

  initial begin
    test_reset();
    test_decode();
    test_backpressure();
    test_illegal();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
